// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word, RAM handshake state and memory arbiter state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISERVE = 2'd1,
        DSERVE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arbiter_if.sv
// Groups the memory arbiter's cache-side and RAM-side signals.
interface arbiter_if;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      ihit;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dhit;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      memerr;

    modport arbiter (
        input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );

    modport tb (
        output CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data accesses.
// Data normally wins; a bounded data streak guarantees fetch progress.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = 4,
    parameter logic [31:0] ERR_CODE    = 32'hBAD1_BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    localparam int unsigned DSW = $clog2(MAX_DSTREAK + 1);

    arb_state_t     state_q, state_d;
    logic [DSW-1:0] dstreak_q, dstreak_d;

    ramstate_t rs;
    logic      dreq;
    logic      done;
    logic      err;
    logic      streak_full;

    assign rs          = ramstate_t'(ramstate);
    assign dreq        = dREN | dWEN;
    assign err         = (rs == ERROR);
    assign done        = (rs == ACCESS) || err;
    assign streak_full = (dstreak_q >= DSW'(MAX_DSTREAK));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
        end
    end

    // RAM outputs and hits are combinational so a hit lands in the ACCESS cycle.
    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        ihit      = 1'b0;
        iload     = '0;
        dhit      = 1'b0;
        dload     = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        memerr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (iREN && (!dreq || streak_full)) begin
                    state_d = ISERVE;
                end else if (dreq) begin
                    state_d = DSERVE;
                end
            end

            ISERVE: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (done) begin
                        ihit      = 1'b1;
                        memerr    = err;
                        iload     = err ? ERR_CODE : ramload;
                        state_d   = IDLE;
                        dstreak_d = '0;
                    end
                end
            end

            DSERVE: begin
                if (!dreq) begin
                    state_d = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = !dWEN;
                    if (done) begin
                        dhit    = 1'b1;
                        memerr  = err;
                        dload   = err ? ERR_CODE : ramload;
                        state_d = IDLE;
                        // Streak only counts data grants taken while fetch was waiting.
                        if (!iREN) begin
                            dstreak_d = '0;
                        end else if (!streak_full) begin
                            dstreak_d = dstreak_q + DSW'(1);
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level owner/streak model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int          MAXD = 4;
    localparam logic [31:0] ERRV = 32'hBAD1_BAD1;

    arbiter_if aif();

    int checks = 0;
    int errors = 0;

    // Model: who currently holds the RAM (0 none, 1 fetch, 2 data) and data-grant streak.
    int m_owner = 0;
    int m_streak = 0;

    logic [132:0] obs;
    assign obs = {aif.ihit, aif.iload, aif.dhit, aif.dload, aif.memerr,
                  aif.ramREN, aif.ramWEN, aif.ramaddr, aif.ramstore};

    mem_arbiter dut (
        .CLK      (aif.CLK),
        .nRST     (aif.nRST),
        .iREN     (aif.iREN),
        .iaddr    (aif.iaddr),
        .ihit     (aif.ihit),
        .iload    (aif.iload),
        .dREN     (aif.dREN),
        .dWEN     (aif.dWEN),
        .daddr    (aif.daddr),
        .dstore   (aif.dstore),
        .dhit     (aif.dhit),
        .dload    (aif.dload),
        .ramREN   (aif.ramREN),
        .ramWEN   (aif.ramWEN),
        .ramaddr  (aif.ramaddr),
        .ramstore (aif.ramstore),
        .ramload  (aif.ramload),
        .ramstate (aif.ramstate),
        .memerr   (aif.memerr)
    );

    initial aif.CLK = 1'b0;
    always #5 aif.CLK = ~aif.CLK;

    function automatic logic [132:0] exp_out();
        logic        ih = 1'b0, dh = 1'b0, me = 1'b0, rr = 1'b0, rw = 1'b0;
        logic [31:0] il = '0, dl = '0, ra = '0, rst = '0;
        logic        fin = (aif.ramstate == ACCESS) || (aif.ramstate == ERROR);
        logic        bad = (aif.ramstate == ERROR);
        if (aif.nRST !== 1'b1) return '0;
        if (m_owner == 1 && aif.iREN) begin
            rr = 1'b1;
            ra = aif.iaddr;
            if (fin) begin
                ih = 1'b1;
                me = bad;
                il = bad ? ERRV : aif.ramload;
            end
        end else if (m_owner == 2 && (aif.dREN || aif.dWEN)) begin
            ra  = aif.daddr;
            rst = aif.dstore;
            rw  = aif.dWEN;
            rr  = !aif.dWEN;
            if (fin) begin
                dh = 1'b1;
                me = bad;
                dl = bad ? ERRV : aif.ramload;
            end
        end
        return {ih, il, dh, dl, me, rr, rw, ra, rst};
    endfunction

    function automatic void advance();
        logic fin  = (aif.ramstate == ACCESS) || (aif.ramstate == ERROR);
        logic dreq = aif.dREN || aif.dWEN;
        case (m_owner)
            0: begin
                if (aif.iREN && (!dreq || m_streak >= MAXD)) m_owner = 1;
                else if (dreq) m_owner = 2;
            end
            1: begin
                if (!aif.iREN) m_owner = 0;
                else if (fin) begin
                    m_owner  = 0;
                    m_streak = 0;
                end
            end
            default: begin
                if (!dreq) m_owner = 0;
                else if (fin) begin
                    m_owner  = 0;
                    m_streak = aif.iREN ? ((m_streak + 1 > MAXD) ? MAXD : m_streak + 1) : 0;
                end
            end
        endcase
    endfunction

    task automatic clear_inputs();
        aif.iREN     = 1'b0;
        aif.iaddr    = '0;
        aif.dREN     = 1'b0;
        aif.dWEN     = 1'b0;
        aif.daddr    = '0;
        aif.dstore   = '0;
        aif.ramload  = '0;
        aif.ramstate = FREE;
    endtask

    task automatic tick();
        advance();
        @(negedge aif.CLK);
    endtask

    task automatic do_reset();
        clear_inputs();
        aif.nRST = 1'b0;
        m_owner  = 0;
        m_streak = 0;
        @(negedge aif.CLK);
        aif.nRST = 1'b1;
    endtask

    task automatic test_reset();
        aif.nRST = 1'b0;
        m_owner  = 0;
        m_streak = 0;
        for (int c = 0; c < 3; c++) begin
            aif.iREN     = 1'b1;
            aif.dREN     = 1'b1;
            aif.dWEN     = c[0];
            aif.iaddr    = $urandom;
            aif.daddr    = $urandom;
            aif.dstore   = $urandom;
            aif.ramload  = $urandom;
            aif.ramstate = ACCESS;
            #1;
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d got=%h want=0", c, obs);
            end
            @(negedge aif.CLK);
        end
        clear_inputs();
        aif.nRST = 1'b1;
    endtask

    task automatic test_ifetch();
        do_reset();
        aif.iREN    = 1'b1;
        aif.iaddr   = 32'h40;
        aif.ramload = 32'h8C01_0004;
        for (int k = 0; k < 5; k++) begin
            logic serve = (k >= 1 && k <= 3);
            logic hit   = (k == 3);
            aif.ramstate = (k == 3) ? ACCESS : BUSY;
            if (k == 4) aif.iREN = 1'b0;
            #1;
            checks++;
            if ({aif.ramREN, aif.ramaddr, aif.ihit, aif.iload} !==
                {serve, (serve ? 32'h40 : 32'h0), hit, (hit ? 32'h8C01_0004 : 32'h0)}) begin
                errors++;
                $display("FAIL ifetch cyc%0d got ren=%b addr=%h hit=%b load=%h want ren=%b hit=%b",
                         k, aif.ramREN, aif.ramaddr, aif.ihit, aif.iload, serve, hit);
            end
            tick();
        end
    endtask

    task automatic test_priority();
        do_reset();
        aif.iREN     = 1'b1;
        aif.dREN     = 1'b1;
        aif.iaddr    = 32'h44;
        aif.daddr    = 32'h100;
        aif.ramload  = 32'h1234_5678;
        aif.ramstate = ACCESS;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) aif.dREN = 1'b0;
            #1;
            checks++;
            case (k)
                1: if (!(aif.dhit === 1'b1 && aif.ramaddr === 32'h100 && aif.ihit === 1'b0)) begin
                       errors++;
                       $display("FAIL priority_data got dhit=%b ihit=%b addr=%h want dhit=1 addr=100",
                                aif.dhit, aif.ihit, aif.ramaddr);
                   end
                3: if (!(aif.ihit === 1'b1 && aif.ramaddr === 32'h44 && aif.dload === 32'h0)) begin
                       errors++;
                       $display("FAIL priority_instr got ihit=%b addr=%h dload=%h want ihit=1 addr=44 dload=0",
                                aif.ihit, aif.ramaddr, aif.dload);
                   end
                default: if (obs !== '0) begin
                       errors++;
                       $display("FAIL priority_idle cyc%0d got=%h want=0", k, obs);
                   end
            endcase
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_streak();
        int nd = 0, first_i = -1, d_after = 0;
        do_reset();
        aif.iREN     = 1'b1;
        aif.dWEN     = 1'b1;
        aif.ramstate = ACCESS;
        for (int c = 0; c < 16; c++) begin
            aif.daddr  = $urandom;
            aif.dstore = $urandom;
            aif.iaddr  = $urandom;
            #1;
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL streak_cycle cyc%0d got=%h want=%h", c, obs, exp_out());
            end
            if (aif.ihit && first_i < 0) first_i = c;
            if (aif.dhit) begin
                if (first_i < 0) nd++;
                else d_after++;
            end
            tick();
        end
        checks++;
        if (nd != MAXD || first_i != 9 || d_after < 1) begin
            errors++;
            $display("FAIL streak_count got dhits=%0d ihit_cyc=%0d resumed=%0d want 4,9,>=1",
                     nd, first_i, d_after);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_write();
        do_reset();
        aif.dREN     = 1'b1;
        aif.dWEN     = 1'b1;
        aif.daddr    = 32'h200;
        aif.dstore   = 32'hDEAD_BEEF;
        aif.ramstate = BUSY;
        tick();
        #1;
        checks++;
        if ({aif.ramWEN, aif.ramREN, aif.ramstore, aif.ramaddr, aif.dhit} !==
            {1'b1, 1'b0, 32'hDEAD_BEEF, 32'h200, 1'b0}) begin
            errors++;
            $display("FAIL write_strobes got wen=%b ren=%b store=%h addr=%h dhit=%b",
                     aif.ramWEN, aif.ramREN, aif.ramstore, aif.ramaddr, aif.dhit);
        end
        tick();
        aif.ramstate = ACCESS;
        #1;
        checks++;
        if (!(aif.dhit === 1'b1 && aif.ramWEN === 1'b1 && aif.memerr === 1'b0)) begin
            errors++;
            $display("FAIL write_done got dhit=%b wen=%b memerr=%b want 1 1 0",
                     aif.dhit, aif.ramWEN, aif.memerr);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_error();
        do_reset();
        aif.iREN     = 1'b1;
        aif.iaddr    = $urandom;
        aif.ramload  = 32'h0F0F_0F0F;
        aif.ramstate = ERROR;
        tick();
        #1;
        checks++;
        if ({aif.ihit, aif.memerr, aif.iload, aif.dhit} !== {1'b1, 1'b1, ERRV, 1'b0}) begin
            errors++;
            $display("FAIL error_hit got ihit=%b memerr=%b iload=%h want 1 1 %h",
                     aif.ihit, aif.memerr, aif.iload, ERRV);
        end
        tick();
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL error_idle got=%h want=0", obs);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_abort_reset();
        int nd = 0, first_i = -1;
        do_reset();
        aif.iREN     = 1'b1;
        aif.dWEN     = 1'b1;
        aif.daddr    = 32'h300;
        aif.ramstate = ACCESS;
        // Three data completions with fetch waiting, then a fourth grant held in BUSY.
        for (int c = 0; c < 8; c++) begin
            if (c == 7) aif.ramstate = BUSY;
            #1;
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL abort_setup cyc%0d got=%h want=%h", c, obs, exp_out());
            end
            if (c < 7) tick();
        end
        aif.nRST = 1'b0;
        m_owner  = 0;
        m_streak = 0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h want=0", obs);
        end
        @(negedge aif.CLK);
        aif.nRST     = 1'b1;
        aif.ramstate = ACCESS;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (aif.ihit && first_i < 0) first_i = c;
            if (aif.dhit && first_i < 0) nd++;
            tick();
        end
        checks++;
        if (nd != MAXD || first_i < 0) begin
            errors++;
            $display("FAIL streak_cleared got dhits_before_ihit=%0d ihit_cyc=%0d want 4", nd, first_i);
        end
        do_reset();
        aif.iREN     = 1'b1;
        aif.iaddr    = 32'h80;
        aif.ramstate = BUSY;
        tick();
        #1;
        checks++;
        if (!(aif.ramREN === 1'b1 && aif.ramaddr === 32'h80)) begin
            errors++;
            $display("FAIL abort_serving got ren=%b addr=%h want 1 80", aif.ramREN, aif.ramaddr);
        end
        tick();
        aif.iREN     = 1'b0;
        aif.ramstate = ACCESS;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL abort_nohit got=%h want=0", obs);
        end
        tick();
        aif.iREN = 1'b1;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL abort_idle got=%h want=0", obs);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) aif.iREN = ~aif.iREN;
            if ($urandom_range(0, 7) == 0) aif.dREN = ~aif.dREN;
            if ($urandom_range(0, 9) == 0) aif.dWEN = ~aif.dWEN;
            aif.iaddr    = $urandom;
            aif.daddr    = $urandom;
            aif.dstore   = $urandom;
            aif.ramload  = $urandom;
            aif.ramstate = ramstate_t'(2'($urandom_range(0, 3)));
            #1;
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL random cyc%0d got=%h want=%h", c, obs, exp_out());
            end
            if ($urandom_range(0, 79) == 0) begin
                aif.nRST = 1'b0;
                m_owner  = 0;
                m_streak = 0;
                #1;
                checks++;
                if (obs !== '0) begin
                    errors++;
                    $display("FAIL random_reset cyc%0d got=%h want=0", c, obs);
                end
                @(negedge aif.CLK);
                aif.nRST = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        clear_inputs();
        aif.nRST = 1'b0;
        @(negedge aif.CLK);
        test_reset();
        test_ifetch();
        test_priority();
        test_streak();
        test_write();
        test_error();
        test_abort_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
